// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the cotm32 five-stage pipeline.
// Converts trap/mret, LSU wait, branch, load-use and WFI conditions into per-register
// stall/flush strobes, a PC stall and a redirect request.
// Optional stall-cycle performance counter: define COTM32_PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 32'd255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_load,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_branch_taken,
  input  logic        i_mem_valid,
  input  logic        i_mem_lsu_busy,
  input  logic        i_mem_trap,
  input  logic        i_mem_mret,
  input  logic        i_mem_wfi_req,
  input  logic        i_irq_pending,
  output logic        o_stall_ifid,
  output logic        o_stall_idex,
  output logic        o_stall_exmem,
  output logic        o_stall_memwb,
  output logic        o_flush_ifid,
  output logic        o_flush_idex,
  output logic        o_flush_exmem,
  output logic        o_flush_memwb,
  output logic        o_pc_stall,
  output logic        o_redirect,
  output logic        o_mem_timeout,
  output logic        o_sleeping
`ifdef COTM32_PIPE_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cycles
`endif
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PERF_W = 32;
  // Counter value seen on the last allowed busy cycle (first busy cycle sees 0).
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 32'd1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2,
    SLEEP    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sleeping_q;

  logic trap_ev, mem_wait, lu_hit, wfi_sleep;
  logic stall_ifid_d, stall_idex_d, stall_exmem_d, stall_memwb_d;
  logic flush_ifid_d, flush_idex_d, flush_exmem_d, flush_memwb_d;
  logic pc_stall_d, redirect_d, timeout_d;

  // Event qualification from the pipeline status inputs.
  always_comb begin
    trap_ev   = i_mem_valid & (i_mem_trap | i_mem_mret);
    mem_wait  = i_mem_valid & i_mem_lsu_busy;
    lu_hit    = i_ex_valid & i_ex_is_load & (i_ex_rd != 5'd0) &
                ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                 (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));
    wfi_sleep = i_mem_valid & i_mem_wfi_req & ~i_irq_pending;
  end

  // Next-state, timeout counter and raw strobe decode, in event priority order.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    stall_ifid_d  = 1'b0;
    stall_idex_d  = 1'b0;
    stall_exmem_d = 1'b0;
    stall_memwb_d = 1'b0;
    flush_ifid_d  = 1'b0;
    flush_idex_d  = 1'b0;
    flush_exmem_d = 1'b0;
    flush_memwb_d = 1'b0;
    pc_stall_d    = 1'b0;
    redirect_d    = 1'b0;
    timeout_d     = 1'b0;

    if (state_q == SLEEP) begin
      // Frozen pipeline; only an interrupt wakes the core.
      stall_ifid_d  = 1'b1;
      stall_idex_d  = 1'b1;
      stall_exmem_d = 1'b1;
      stall_memwb_d = 1'b1;
      pc_stall_d    = 1'b1;
      state_d       = i_irq_pending ? RUN : SLEEP;
    end else begin
      state_d = RUN;
      // Fetch lags the redirect by one cycle, so its first slot is dropped too.
      if (state_q == REDIRECT) begin
        flush_ifid_d = 1'b1;
      end

      if (trap_ev) begin
        redirect_d    = 1'b1;
        flush_ifid_d  = 1'b1;
        flush_idex_d  = 1'b1;
        flush_exmem_d = 1'b1;
        state_d       = REDIRECT;
      end else if (mem_wait) begin
        pc_stall_d    = 1'b1;
        stall_ifid_d  = 1'b1;
        stall_idex_d  = 1'b1;
        stall_exmem_d = 1'b1;
        flush_memwb_d = 1'b1;
        if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = RUN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = MEM_WAIT;
        end
      end else begin
        if (i_ex_branch_taken) begin
          redirect_d   = 1'b1;
          flush_ifid_d = 1'b1;
          flush_idex_d = 1'b1;
        end else if (lu_hit) begin
          pc_stall_d   = 1'b1;
          stall_ifid_d = 1'b1;
          flush_idex_d = 1'b1;
        end
        if (wfi_sleep) begin
          state_d = SLEEP;
        end
      end
    end
  end

  // Outputs: flush beats stall per register; everything held low while in reset.
  assign o_flush_ifid  = i_rst_n & flush_ifid_d;
  assign o_flush_idex  = i_rst_n & flush_idex_d;
  assign o_flush_exmem = i_rst_n & flush_exmem_d;
  assign o_flush_memwb = i_rst_n & flush_memwb_d;
  assign o_stall_ifid  = i_rst_n & stall_ifid_d  & ~flush_ifid_d;
  assign o_stall_idex  = i_rst_n & stall_idex_d  & ~flush_idex_d;
  assign o_stall_exmem = i_rst_n & stall_exmem_d & ~flush_exmem_d;
  assign o_stall_memwb = i_rst_n & stall_memwb_d & ~flush_memwb_d;
  assign o_pc_stall    = i_rst_n & pc_stall_d;
  assign o_redirect    = i_rst_n & redirect_d;
  assign o_mem_timeout = i_rst_n & timeout_d;
  assign o_sleeping    = sleeping_q;

  // Controller state, LSU-wait counter and registered sleep flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      sleeping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sleeping_q <= (state_d == SLEEP);
    end
  end

`ifdef COTM32_PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles_q;

  // Count every PC-stall cycle, sleep included; wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles_q <= '0;
    end else if (pc_stall_d) begin
      stall_cycles_q <= stall_cycles_q + PERF_W'(1);
    end
  end

  assign o_stall_cycles = stall_cycles_q;
`endif

endmodule
